// File: rtl/fnd_scan_driver_pkg.sv
// Shared display constants for the 4-digit FND scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package fnd_scan_driver_pkg;

  localparam int DEF_SCAN_TICKS       = 1;
  localparam int DEF_BLINK_HALF_TICKS = 500;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/fnd_scan_driver_if.sv
// Display bus bundle: tick/data/masks in, anode/segment/dot out.
// Master drives the inputs, slave is the scan driver side.
interface fnd_scan_driver_if;

  logic        tick;
  logic [15:0] data;
  logic [3:0]  blink;
  logic [3:0]  dot;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output tick, data, blink, dot,
    input  an, seg, dp
  );

  modport slave (
    input  tick, data, blink, dot,
    output an, seg, dp
  );

endinterface

// File: rtl/fnd_seg_decoder.sv
// BCD to active-low 7-segment pattern.
// Non-decimal codes blank the digit.
module fnd_seg_decoder
  import fnd_scan_driver_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup; codes 10-15 fall to blank
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit multiplexed FND driver with frame-latched data,
// per-digit blink and decimal points; outputs registered.
module fnd_scan_driver
  import fnd_scan_driver_pkg::*;
#(
  parameter int P_SCAN_TICKS       = DEF_SCAN_TICKS,
  parameter int P_BLINK_HALF_TICKS = DEF_BLINK_HALF_TICKS
) (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic        iTick1kHz,
  input  logic [15:0] iFndData,
  input  logic [3:0]  iBlinkMask,
  input  logic [3:0]  iDotMask,
  output logic [3:0]  oAn,
  output logic [6:0]  oSeg,
  output logic        oDp
);

  localparam int SW = (P_SCAN_TICKS > 1) ?
                      $clog2(P_SCAN_TICKS) : 1;
  localparam int BW = (P_BLINK_HALF_TICKS > 1) ?
                      $clog2(P_BLINK_HALF_TICKS) : 1;

  localparam logic [SW-1:0] SCAN_LAST  =
    SW'(P_SCAN_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST =
    BW'(P_BLINK_HALF_TICKS - 1);

  logic [SW-1:0] dwell_q, dwell_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [15:0]   data_sh_q, data_sh_d;
  logic [3:0]    blink_sh_q, blink_sh_d;
  logic [3:0]    dot_sh_q, dot_sh_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          scan_last;
  logic          frame_wrap;
  logic          blink_last;
  logic [3:0]    cur_bcd;
  logic [6:0]    cur_seg;
  logic          hidden;

  assign scan_last  = iTick1kHz && (dwell_q == SCAN_LAST);
  assign frame_wrap = scan_last && (idx_q == 2'd3);
  assign blink_last = iTick1kHz && (bcnt_q == BLINK_LAST);

  assign cur_bcd = data_sh_q[int'(idx_q)*4 +: 4];
  assign hidden  = blink_sh_q[idx_q] & phase_q;

  fnd_seg_decoder u_dec (
    .bcd_i (cur_bcd),
    .seg_o (cur_seg)
  );

  // State register: counters, shadows and output flops
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      dwell_q    <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      data_sh_q  <= '0;
      blink_sh_q <= '0;
      dot_sh_q   <= '0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      dwell_q    <= dwell_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      data_sh_q  <= data_sh_d;
      blink_sh_q <= blink_sh_d;
      dot_sh_q   <= dot_sh_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  // Next state: dwell/index scan, blink timer, frame latch
  always_comb begin
    dwell_d    = dwell_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    phase_d    = phase_q;
    data_sh_d  = data_sh_q;
    blink_sh_d = blink_sh_q;
    dot_sh_d   = dot_sh_q;
    if (iTick1kHz) begin
      dwell_d = scan_last ? '0 : dwell_q + 1'b1;
      bcnt_d  = blink_last ? '0 : bcnt_q + 1'b1;
    end
    if (scan_last)
      idx_d = idx_q + 2'd1;
    if (blink_last)
      phase_d = ~phase_q;
    if (frame_wrap) begin
      data_sh_d  = iFndData;
      blink_sh_d = iBlinkMask;
      dot_sh_d   = iDotMask;
    end
  end

  // Outputs: drive the current digit from shadow state
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = hidden ? SEG_BLANK : cur_seg;
    dp_d  = ~(dot_sh_q[idx_q] & ~hidden);
  end

  assign oAn  = an_q;
  assign oSeg = seg_q;
  assign oDp  = dp_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver with scan=1, blink half=4.
// Expected patterns are hand-computed per tick count.
module tb_fnd_scan_driver;

  localparam logic [6:0] E0 = 7'b1000000;
  localparam logic [6:0] E1 = 7'b1111001;
  localparam logic [6:0] E2 = 7'b0100100;
  localparam logic [6:0] E3 = 7'b0110000;
  localparam logic [6:0] E4 = 7'b0011001;
  localparam logic [6:0] E5 = 7'b0010010;
  localparam logic [6:0] E6 = 7'b0000010;
  localparam logic [6:0] E7 = 7'b1111000;
  localparam logic [6:0] E8 = 7'b0000000;
  localparam logic [6:0] E9 = 7'b0010000;
  localparam logic [6:0] EB = 7'h7F;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  fnd_scan_driver_if bus ();

  always #5 clk = ~clk;

  fnd_scan_driver #(
    .P_SCAN_TICKS       (1),
    .P_BLINK_HALF_TICKS (4)
  ) dut (
    .iClk       (clk),
    .iRstn      (rstn),
    .iTick1kHz  (bus.tick),
    .iFndData   (bus.data),
    .iBlinkMask (bus.blink),
    .iDotMask   (bus.dot),
    .oAn        (bus.an),
    .oSeg       (bus.seg),
    .oDp        (bus.dp)
  );

  task automatic chk(input string tag,
                     input logic [3:0] ea,
                     input logic [6:0] es,
                     input logic ed);
    tests++;
    assert ({bus.an, bus.seg, bus.dp} === {ea, es, ed})
    else begin
      fails++;
      $error("FAIL %s: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
             tag, bus.an, bus.seg, bus.dp, ea, es, ed);
    end
  endtask

  // one-cycle tick, then one more edge so outputs show new index
  task automatic tick;
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.tick  = 1'b0;
    bus.data  = 16'h0000;
    bus.blink = 4'b0000;
    bus.dot   = 4'b0000;

    // reset
    repeat (3) @(negedge clk);
    chk("reset", 4'b1111, EB, 1'b1);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset", 4'b1110, E0, 1'b1);

    // scan and latch (n = ticks since reset)
    bus.data = 16'h1234;
    tick(); chk("n1_zero_shadow", 4'b1101, E0, 1'b1);
    tick(); chk("n2_zero_shadow", 4'b1011, E0, 1'b1);
    tick(); chk("n3_zero_shadow", 4'b0111, E0, 1'b1);
    tick(); chk("n4_d0_4", 4'b1110, E4, 1'b1);
    tick(); chk("n5_d1_3", 4'b1101, E3, 1'b1);
    tick(); chk("n6_d2_2", 4'b1011, E2, 1'b1);
    tick(); chk("n7_d3_1", 4'b0111, E1, 1'b1);
    tick(); chk("n8_d0_4", 4'b1110, E4, 1'b1);

    // tear-free update
    tick(); chk("n9_d1_3", 4'b1101, E3, 1'b1);
    bus.data = 16'h5678;
    tick(); chk("n10_old_d2", 4'b1011, E2, 1'b1);
    tick(); chk("n11_old_d3", 4'b0111, E1, 1'b1);
    tick(); chk("n12_new_d0", 4'b1110, E8, 1'b1);
    tick(); chk("n13_new_d1", 4'b1101, E7, 1'b1);

    // no ticks: everything holds
    repeat (6) @(negedge clk);
    chk("hold", 4'b1101, E7, 1'b1);

    tick(); chk("n14_d2_6", 4'b1011, E6, 1'b1);
    tick(); chk("n15_d3_5", 4'b0111, E5, 1'b1);
    tick(); chk("n16_d0_8", 4'b1110, E8, 1'b1);

    // blink on digit 2, latched at n=20
    bus.blink = 4'b0100;
    bus.data  = 16'h1234;
    tick(); chk("n17_prev_frame", 4'b1101, E7, 1'b1);
    tick(); chk("n18_no_blink", 4'b1011, E6, 1'b1);
    tick(); tick();
    chk("n20_d0_vis", 4'b1110, E4, 1'b1);
    tick(); chk("n21_d1_vis", 4'b1101, E3, 1'b1);
    tick(); chk("n22_d2_hidden", 4'b1011, EB, 1'b1);
    tick(); chk("n23_d3_vis", 4'b0111, E1, 1'b1);
    tick(); tick(); tick();
    chk("n26_d2_shown", 4'b1011, E2, 1'b1);
    tick(); tick(); tick(); tick();
    chk("n30_d2_hidden", 4'b1011, EB, 1'b1);

    // dots and invalid codes, latched at n=32
    bus.blink = 4'b0000;
    bus.dot   = 4'b0100;
    bus.data  = 16'hF0A9;
    tick(); tick();
    chk("n32_d0_9", 4'b1110, E9, 1'b1);
    tick(); chk("n33_d1_A_blank", 4'b1101, EB, 1'b1);
    tick(); chk("n34_d2_dot", 4'b1011, E0, 1'b0);
    tick(); chk("n35_d3_F_blank", 4'b0111, EB, 1'b1);

    // hidden digit suppresses its dot (latch n=36, phase 1)
    bus.blink = 4'b0100;
    tick(); chk("n36_d0_9", 4'b1110, E9, 1'b1);
    tick(); tick();
    chk("n38_hidden_no_dp", 4'b1011, EB, 1'b1);

    // reset mid-frame: shadows and counters restart
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset", 4'b1111, EB, 1'b1);
    rstn = 1'b1;
    @(negedge clk);
    chk("midreset_rel", 4'b1110, E0, 1'b1);
    tick(); chk("mr_n1_zero", 4'b1101, E0, 1'b1);
    tick(); tick(); tick();
    chk("mr_n4_latch", 4'b1110, E9, 1'b1);
    tick(); tick();
    chk("mr_n6_hidden", 4'b1011, EB, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
